// File: rtl/soc_system_pio_flags_irq.sv
// -----------------------------------------------------------------------------
// soc_system_pio_flags_irq
//
// Avalon-MM status-flag PIO with edge capture and level interrupt. WIDTH
// asynchronous flag inputs pass through a SYNC_STAGES-deep synchroniser. The
// selected edges (EDGE_TYPE: 0 rising, 1 falling, 2 any) latch into a sticky
// EDGECAPTURE register. irq is raised while any captured bit is unmasked.
//
// Optional build macro PIO_FLAGS_DEBOUNCE_EN inserts a per-bit debounce filter
// after the synchroniser. A bit must hold its new value for DEBOUNCE_CYCLES
// consecutive clocks before it is accepted. Without the macro the filter and
// its counters are absent and DEBOUNCE_CYCLES has no effect.
//
// Register map (word addresses):
//   0 DATA        RO   filtered/synchronised input value
//   1 IRQMASK     RW   per-bit interrupt enable
//   2 reserved         reads 0, writes ignored
//   3 EDGECAPTURE R/W1C sticky edge flags
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   address     Avalon word address [1:0]
//   chipselect  Avalon select (qualifies writes only)
//   write_n     Avalon write strobe, active-low
//   writedata   Avalon write data [31:0] (only [WIDTH-1:0] used)
//   readdata    Avalon read data [31:0], registered, 1-cycle latency
//   in_port     asynchronous flag inputs [WIDTH-1:0]
//   irq         registered level interrupt
// -----------------------------------------------------------------------------
module soc_system_pio_flags_irq #(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int                 PRIME_W   = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_MAX = PRIME_W'(SYNC_STAGES + 1);

    if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 4 ||
        EDGE_TYPE < 0 || EDGE_TYPE > 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
        $error("soc_system_pio_flags_irq: parameter out of range");
    end

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   s;
    logic [WIDTH-1:0]   f;
    logic [WIDTH-1:0]   prev;
    logic [WIDTH-1:0]   mask;
    logic [WIDTH-1:0]   edgecapture;
    logic [WIDTH-1:0]   edge_det;
    logic [WIDTH-1:0]   w1c;
    logic [PRIME_W-1:0] prime_cnt;
    logic               primed;
    logic               wr_en;
    logic [31:0]        rd_mux;
    logic               unused_wdata;

    assign s            = sync_q[SYNC_STAGES-1];
    assign primed       = (prime_cnt == PRIME_MAX);
    assign wr_en        = chipselect & ~write_n;
    assign w1c          = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    assign unused_wdata = ^writedata;

    // Synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour; blocking here would
        // collapse the chain into a single stage.
        if (reset) begin
            // NOTE: the chain is a small register array, not a RAM, so every
            // stage can and should be reset.
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

`ifdef PIO_FLAGS_DEBOUNCE_EN
    localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_W-1:0]  db_cnt [WIDTH];
    logic [WIDTH-1:0] f_q;

    // A bit is accepted on the DEBOUNCE_CYCLES-th consecutive cycle that s
    // disagrees with f; any agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_q <= '0;
            for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s[i] == f_q[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    f_q[i]    <= s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign f = f_q;
`else
    assign f = s;
`endif

    // Edge selection, suppressed until the pipeline has settled after reset
    // so inputs already high at reset never look like a fresh edge.
    always_comb begin
        // NOTE: give every always_comb output a default first; a path that
        // leaves it unassigned would infer a latch.
        edge_det = '0;
        if (primed) begin
            case (EDGE_TYPE)
                0:       edge_det = f & ~prev;
                1:       edge_det = ~f & prev;
                default: edge_det = (f & ~prev) | (~f & prev);
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA: rd_mux[WIDTH-1:0] = f;
            ADDR_MASK: rd_mux[WIDTH-1:0] = mask;
            ADDR_EDGE: rd_mux[WIDTH-1:0] = edgecapture;
            default:   rd_mux            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev        <= '0;
            mask        <= '0;
            edgecapture <= '0;
            prime_cnt   <= '0;
            readdata    <= '0;
            irq         <= 1'b0;
        end else begin
            prev <= f;
            if (!primed) prime_cnt <= prime_cnt + 1'b1;
            if (wr_en && address == ADDR_MASK) mask <= writedata[WIDTH-1:0];
            // A new edge beats a simultaneous clear so no event is lost.
            edgecapture <= edge_det | (edgecapture & ~w1c);
            irq         <= |(edgecapture & mask);
            readdata    <= rd_mux;
        end
    end

endmodule

// File: tb/tb_soc_system_pio_flags_irq.sv
// -----------------------------------------------------------------------------
// tb_soc_system_pio_flags_irq
//
// Directed bench for soc_system_pio_flags_irq. Three instances share one bus:
//   dut_a  defaults (WIDTH 4, rising edge)
//   dut_b  WIDTH 8, falling edge
//   dut_c  WIDTH 4, any edge
// Outputs are sampled 1 time unit after the rising clock edge.
// -----------------------------------------------------------------------------
module tb_soc_system_pio_flags_irq;

`ifdef PIO_FLAGS_DEBOUNCE_EN
    localparam logic [3:0] INIT_A = 4'h0;
`else
    localparam logic [3:0] INIT_A = 4'hF;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;

    logic [3:0]  in_port_a;
    logic [7:0]  in_port_b;
    logic [3:0]  in_port_c;
    logic [31:0] readdata_a, readdata_b, readdata_c;
    logic        irq_a, irq_b, irq_c;

    int          pass_cnt  = 0;
    int          total_cnt = 0;
    logic [31:0] exp_rst_rd;

    always #5 clk = ~clk;

    soc_system_pio_flags_irq dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_a),
        .in_port(in_port_a), .irq(irq_a)
    );

    soc_system_pio_flags_irq #(.WIDTH(8), .EDGE_TYPE(1)) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
        .in_port(in_port_b), .irq(irq_b)
    );

    soc_system_pio_flags_irq #(.WIDTH(4), .EDGE_TYPE(2)) dut_c (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata_c),
        .in_port(in_port_c), .irq(irq_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else             pass_cnt++;
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    // readdata is valid after the edge that follows the address being driven.
    task automatic bus_read(input logic [1:0] a);
        address    = a;
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port_a  = INIT_A;
        in_port_b  = 8'hFF;
        in_port_c  = 4'h0;

        #1;
        check("rst_readdata", readdata_a, 32'h0);
        check("rst_irq", {31'b0, irq_a}, 32'h0);
        wait_clk(3);
        reset = 1'b0;
        wait_clk(10);

        // Inputs high through reset must not capture.
        bus_read(2'd3);
        check("prime_cap", readdata_a, 32'h0);
        check("prime_irq", {31'b0, irq_a}, 32'h0);
        bus_read(2'd0);
        check("prime_data", readdata_a, {28'b0, INIT_A});
        bus_read(2'd1);
        check("rst_mask", readdata_a, 32'h0);
        bus_read(2'd2);
        check("rsvd_read", readdata_a, 32'h0);

`ifdef PIO_FLAGS_DEBOUNCE_EN
        bus_write(2'd1, 32'hF);
        in_port_a = 4'h2;
        wait_clk(10);
        in_port_a = 4'h0;
        wait_clk(30);
        bus_read(2'd3);
        check("db_short", readdata_a, 32'h0);
        in_port_a = 4'h2;
        wait_clk(20);
        wait_clk(10);
        bus_read(2'd3);
        check("db_long", readdata_a, 32'h2);
        check("db_irq", {31'b0, irq_a}, 32'h1);
        exp_rst_rd = 32'h2;
`else
        // Falling edges ignored in rising mode.
        in_port_a = 4'h0;
        wait_clk(6);
        bus_read(2'd3);
        check("fall_ignored", readdata_a, 32'h0);

        // Rising capture with mask 0: captured but no interrupt.
        in_port_a = 4'h5;
        wait_clk(5);
        bus_read(2'd3);
        check("rise_cap", readdata_a, 32'h5);
        check("masked_irq", {31'b0, irq_a}, 32'h0);
        bus_write(2'd1, 32'h4);
        check("irq_pre_mask", {31'b0, irq_a}, 32'h0);
        wait_clk(1);
        check("irq_mask", {31'b0, irq_a}, 32'h1);
        bus_read(2'd1);
        check("mask_rb", readdata_a, 32'h4);

        // Writes to DATA and reserved are ignored.
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check("wr_ignored_mask", readdata_a, 32'h4);
        bus_read(2'd3);
        check("wr_ignored_cap", readdata_a, 32'h5);

        // Upper mask bits read 0; W1C sequence.
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1);
        check("mask_width", readdata_a, 32'hF);
        bus_write(2'd3, 32'h4);
        check("irq_w1c_a", {31'b0, irq_a}, 32'h1);
        bus_read(2'd3);
        check("w1c_bit2", readdata_a, 32'h1);
        check("irq_hold", {31'b0, irq_a}, 32'h1);
        bus_write(2'd3, 32'h1);
        check("irq_lag", {31'b0, irq_a}, 32'h1);
        wait_clk(1);
        check("irq_clear", {31'b0, irq_a}, 32'h0);
        bus_read(2'd3);
        check("w1c_all", readdata_a, 32'h0);

        // Rising edge on bit 2 coincides with a W1C of bit 2.
        in_port_a = 4'h1;
        wait_clk(6);
        bus_read(2'd3);
        check("fall2_ignored", readdata_a, 32'h0);
        in_port_a = 4'h5;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus_write(2'd3, 32'h4);
        bus_read(2'd3);
        check("set_wins", readdata_a, 32'h4);
        check("irq_set_wins", {31'b0, irq_a}, 32'h1);

        // Falling-edge instance, WIDTH 8.
        in_port_b = 8'h0F;
        wait_clk(6);
        bus_read(2'd3);
        check("fall_cap_w8", readdata_b, 32'hF0);
        check("irq_w8", {31'b0, irq_b}, 32'h1);
        bus_read(2'd0);
        check("data_w8", readdata_b, 32'h0F);

        // Any-edge instance: 3-cycle pulse captures once, W1C, no recapture.
        in_port_c = 4'h1;
        wait_clk(3);
        in_port_c = 4'h0;
        wait_clk(6);
        bus_read(2'd3);
        check("any_cap", readdata_c, 32'h1);
        bus_write(2'd3, 32'h1);
        wait_clk(6);
        bus_read(2'd3);
        check("any_no_recap", readdata_c, 32'h0);
        check("a_cap_kept", readdata_a, 32'h4);
        in_port_c = 4'h1;
        wait_clk(6);
        bus_read(2'd3);
        check("any_next_edge", readdata_c, 32'h1);
        exp_rst_rd = 32'h4;
`endif

        // Asynchronous reset mid-cycle with irq high.
        bus_read(2'd3);
        check("pre_rst_rd", readdata_a, exp_rst_rd);
        check("pre_rst_irq", {31'b0, irq_a}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_irq", {31'b0, irq_a}, 32'h0);
        check("async_rst_rd", readdata_a, 32'h0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(10);
        bus_read(2'd3);
        check("reprime_cap", readdata_a, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
